memory_stage: RTL and testbench

Memory/writeback pipeline stage directly downstream of the execute stage. Registers the execute result into an M stage, issues loads and stores to the data cache over a valid/ready request and valid response interface, and aligns store data and byte enables. Sign- or zero-extends load data into a W stage. Supplies execute with the `previous`/`writeback` forwarding values and the `prev_*`/`wb_*` hazard fields, and freezes upstream with `stall` while a memory access is outstanding.

---
 rtl/memory_stage.sv | 183 ++++++++++++++++++
 tb/tb_memory_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory/writeback stage: M and W registers, data-cache request FSM, store lane steering and load
// extraction. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_mem_rr,
  input  logic        ex_mem_we,
  output logic        stall,
  output logic [31:0] previous,
  output logic [4:0]  prev_rd,
  output logic        prev_reg_we,
  output logic        prev_mem_rr,
  output logic [31:0] writeback,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_we,
  output logic        wb_mem_rr,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_we,
  output logic [31:0] dc_din,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_dout,
  output logic        misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic        m_valid;
  logic [31:0] m_result;
  logic [31:0] m_store_data;
  logic [2:0]  m_funct3;
  logic [4:0]  m_rd;
  logic        m_reg_we;
  logic        m_mem_rr;
  logic        m_mem_we;

  logic [1:0]  state_q, state_d, cur_state;
  logic        misalign_now;
  logic        m_mem;
  logic        next_mem;
  logic        handshake;
  logic        complete;
  logic [31:0] load_shift;
  logic [31:0] load_data;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  always_comb begin
    misalign_now = m_valid & (m_mem_rr | m_mem_we) &
                   (((m_funct3[1:0] == 2'b01) & m_result[0]) |
                    ((m_funct3[1:0] == 2'b10) & (|m_result[1:0])));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_q | misalign_now;
  end

  assign misalign = misalign_q;
`else
  assign misalign_now = 1'b0;
  assign misalign     = 1'b0;
`endif

  assign m_mem    = m_valid & (m_mem_rr | m_mem_we) & ~misalign_now;
  assign next_mem = ex_valid & (ex_mem_rr | ex_mem_we);

  // A fresh memory op in IDLE behaves as REQ in the same cycle; a non-memory M entry is always IDLE.
  assign cur_state    = m_mem ? ((state_q == IDLE) ? REQ : state_q) : IDLE;
  assign dc_req_valid = (cur_state == REQ);
  assign handshake    = dc_req_valid & dc_req_ready;
  assign complete     = (handshake & m_mem_we) | ((cur_state == RESP) & dc_resp_valid);
  assign stall        = m_mem & ~complete;

  always_comb begin
    state_d = IDLE;
    case (cur_state)
      REQ: begin
        if (!handshake)    state_d = REQ;
        else if (m_mem_we) state_d = next_mem ? REQ : IDLE;
        else               state_d = RESP;
      end
      RESP: begin
        if (dc_resp_valid) state_d = next_mem ? REQ : IDLE;
        else               state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign dc_addr = {m_result[31:2], 2'b00};

  always_comb begin
    dc_we  = 4'b1111;
    dc_din = m_store_data;
    case (m_funct3[1:0])
      2'b00: begin
        dc_we  = 4'b0001 << m_result[1:0];
        dc_din = {4{m_store_data[7:0]}};
      end
      2'b01: begin
        dc_we  = 4'b0011 << {m_result[1], 1'b0};
        dc_din = {2{m_store_data[15:0]}};
      end
      default: dc_we = 4'b1111;
    endcase
    if (!(m_valid & m_mem_we)) dc_we = 4'b0000;
  end

  assign load_shift = dc_dout >> {m_result[1:0], 3'b000};

  always_comb begin
    load_data = load_shift;
    case (m_funct3)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_data = {24'd0, load_shift[7:0]};
      3'b101:  load_data = {16'd0, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_result     <= 32'd0;
      m_store_data <= 32'd0;
      m_funct3     <= 3'd0;
      m_rd         <= 5'd0;
      m_reg_we     <= 1'b0;
      m_mem_rr     <= 1'b0;
      m_mem_we     <= 1'b0;
    end else if (!stall) begin
      m_valid      <= ex_valid;
      m_result     <= ex_result;
      m_store_data <= ex_store_data;
      m_funct3     <= ex_funct3;
      m_rd         <= ex_rd;
      m_reg_we     <= ex_reg_we;
      m_mem_rr     <= ex_mem_rr;
      m_mem_we     <= ex_mem_we;
    end
  end

  assign previous    = m_result;
  assign prev_rd     = m_rd;
  assign prev_reg_we = m_valid & m_reg_we;
  assign prev_mem_rr = m_valid & m_mem_rr;

  // While stalled the W stage takes a bubble; data fields are left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeback <= 32'd0;
      wb_rd     <= 5'd0;
      wb_reg_we <= 1'b0;
      wb_mem_rr <= 1'b0;
    end else if (stall) begin
      wb_reg_we <= 1'b0;
      wb_mem_rr <= 1'b0;
    end else begin
      writeback <= (m_valid & m_mem_rr) ? load_data : m_result;
      wb_rd     <= m_rd;
      wb_reg_we <= m_valid & m_reg_we & ~misalign_now;
      wb_mem_rr <= m_valid & m_mem_rr & ~misalign_now;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: scoreboard of expected writebacks plus directed checks
// around a behavioural data-cache responder with programmable ready and response latency.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_mem_rr;
  logic        ex_mem_we;
  logic        stall;
  logic [31:0] previous;
  logic [4:0]  prev_rd;
  logic        prev_reg_we;
  logic        prev_mem_rr;
  logic [31:0] writeback;
  logic [4:0]  wb_rd;
  logic        wb_reg_we;
  logic        wb_mem_rr;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [31:0] dc_addr;
  logic [3:0]  dc_we;
  logic [31:0] dc_din;
  logic        dc_resp_valid;
  logic [31:0] dc_dout;
  logic        misalign;

  memory_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_funct3     (ex_funct3),
    .ex_rd         (ex_rd),
    .ex_reg_we     (ex_reg_we),
    .ex_mem_rr     (ex_mem_rr),
    .ex_mem_we     (ex_mem_we),
    .stall         (stall),
    .previous      (previous),
    .prev_rd       (prev_rd),
    .prev_reg_we   (prev_reg_we),
    .prev_mem_rr   (prev_mem_rr),
    .writeback     (writeback),
    .wb_rd         (wb_rd),
    .wb_reg_we     (wb_reg_we),
    .wb_mem_rr     (wb_mem_rr),
    .dc_req_valid  (dc_req_valid),
    .dc_req_ready  (dc_req_ready),
    .dc_addr       (dc_addr),
    .dc_we         (dc_we),
    .dc_din        (dc_din),
    .dc_resp_valid (dc_resp_valid),
    .dc_dout       (dc_dout),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int stall_cycles = 0;
  int last_wb_cyc = -1;

  logic [36:0] sb_q[$];
  logic [67:0] req_log[$];
  int          req_cyc[$];
  logic        wb_hist [256];

  int          ready_lat = 0;
  int          resp_lat = 1;
  logic [31:0] resp_data = 32'd0;
  logic        stray = 1'b0;

  logic        hs_any = 1'b0;
  logic        hs_load = 1'b0;
  logic        req_waiting = 1'b0;
  logic [68:0] held_req = '0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Output monitor: scoreboard pops, stall counting, request logging and request stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall) stall_cycles++;
      wb_hist[cyc_n[7:0]] = wb_reg_we;
      if (wb_reg_we) begin
        last_wb_cyc = cyc_n;
        if (sb_q.size() == 0) chk("wb_unexpected", 72'd1, 72'd0);
        else chk("wb_data", {35'd0, wb_rd, writeback}, {35'd0, sb_q.pop_front()});
      end
      if (req_waiting)
        chk("req_stable", {3'd0, dc_req_valid, dc_addr, dc_we, dc_din}, {3'd0, held_req});
      req_waiting = dc_req_valid & ~dc_req_ready;
      held_req    = {1'b1, dc_addr, dc_we, dc_din};
      hs_any      = dc_req_valid & dc_req_ready;
      hs_load     = dc_req_valid & dc_req_ready & (dc_we == 4'd0);
      if (hs_any) begin
        req_log.push_back({dc_addr, dc_we, dc_din});
        req_cyc.push_back(cyc_n);
      end
    end else begin
      req_waiting = 1'b0;
      hs_any      = 1'b0;
      hs_load     = 1'b0;
    end
  end

  // Data-cache model.
  initial begin
    int  wait_cnt;
    int  resp_cnt;
    logic pending;
    wait_cnt = 0;
    resp_cnt = 0;
    pending = 1'b0;
    dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0;
    dc_dout = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        dc_req_ready = 1'b0;
        dc_resp_valid = 1'b0;
        pending = 1'b0;
        wait_cnt = 0;
      end else begin
        dc_resp_valid = stray;
        dc_dout = 32'h5A5A_0F0F;
        if (hs_load) begin
          pending = 1'b1;
          resp_cnt = 1;
        end else if (pending) begin
          resp_cnt++;
        end
        if (pending && resp_cnt == resp_lat) begin
          dc_resp_valid = 1'b1;
          dc_dout = resp_data;
          pending = 1'b0;
        end
        if (hs_any) wait_cnt = 0;
        if (dc_req_valid) begin
          dc_req_ready = (wait_cnt >= ready_lat);
          if (!dc_req_ready) wait_cnt++;
        end else begin
          dc_req_ready = 1'b0;
        end
      end
    end
  end

  task automatic idle_ex();
    ex_valid = 1'b0;
    ex_result = 32'd0;
    ex_store_data = 32'd0;
    ex_funct3 = 3'd0;
    ex_rd = 5'd0;
    ex_reg_we = 1'b0;
    ex_mem_rr = 1'b0;
    ex_mem_we = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until accepted; returns one cycle after acceptance.
  task automatic issue(input logic [31:0] res, input logic [31:0] sd, input logic [2:0] f3,
                       input logic [4:0] rd, input logic rwe, input logic rr, input logic we,
                       input logic push, input logic [31:0] exp);
    logic accepted;
    accepted = 1'b0;
    ex_valid = 1'b1;
    ex_result = res;
    ex_store_data = sd;
    ex_funct3 = f3;
    ex_rd = rd;
    ex_reg_we = rwe;
    ex_mem_rr = rr;
    ex_mem_we = we;
    if (push) sb_q.push_back({rd, exp});
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = !stall;
      next_cycle();
    end
    if (!accepted) chk("issue_timeout", 72'd1, 72'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) next_cycle();
    chk("drain", 72'(sb_q.size()), 72'd0);
  endtask

  initial begin
    int t0;
    int s0;
    int n0;
    logic [31:0] lb_exp [2];
    logic [2:0]  lb_f3 [2];
    lb_exp[0] = 32'hFFFF_FF80;
    lb_exp[1] = 32'h0000_0080;
    lb_f3[0]  = 3'b000;
    lb_f3[1]  = 3'b100;

    rst = 1'b1;
    idle_ex();
    @(negedge clk);
    chk("rst_stall", 72'(stall), 72'd0);
    chk("rst_req_valid", 72'(dc_req_valid), 72'd0);
    chk("rst_dc_we", 72'(dc_we), 72'd0);
    chk("rst_misalign", 72'(misalign), 72'd0);
    chk("rst_prev", {34'd0, prev_reg_we, prev_mem_rr, prev_rd, previous}, 72'd0);
    chk("rst_wb", {34'd0, wb_reg_we, wb_mem_rr, wb_rd, writeback}, 72'd0);
    chk("rst_dc_addr_din", {8'd0, dc_addr, dc_din}, 72'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // ALU op
    s0 = stall_cycles;
    issue(32'h1234, 32'd0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234);
    idle_ex();
    @(negedge clk);
    chk("alu_previous", 72'(previous), 72'h1234);
    chk("alu_prev_rd", 72'(prev_rd), 72'd5);
    chk("alu_prev_reg_we", 72'(prev_reg_we), 72'd1);
    next_cycle();
    @(negedge clk);
    chk("alu_wb_reg_we", 72'(wb_reg_we), 72'd1);
    chk("alu_writeback", 72'(writeback), 72'h1234);
    chk("alu_no_stall", 72'(stall_cycles - s0), 72'd0);
    next_cycle();

    // LB / LBU, response three cycles after the handshake
    ready_lat = 0;
    resp_lat = 3;
    resp_data = 32'h80AA_BBCC;
    for (int v = 0; v < 2; v++) begin
      s0 = stall_cycles;
      t0 = cyc_n;
      issue(32'h1003, 32'd0, lb_f3[v], 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, lb_exp[v]);
      idle_ex();
      @(negedge clk);
      chk("lb_req_valid", 72'(dc_req_valid), 72'd1);
      chk("lb_dc_addr", 72'(dc_addr), 72'h1000);
      chk("lb_dc_we", 72'(dc_we), 72'd0);
      chk("lb_stall", 72'(stall), 72'd1);
      next_cycle();
      wait_drain();
      chk("lb_wb_cycle", 72'(last_wb_cyc), 72'(t0 + 5));
      chk("lb_stall_cycles", 72'(stall_cycles - s0), 72'd3);
      next_cycle();
    end

    // SH with ready held low for two cycles
    ready_lat = 2;
    s0 = stall_cycles;
    n0 = req_log.size();
    issue(32'h2002, 32'hDEAD_BEEF, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    idle_ex();
    @(negedge clk);
    chk("sh_req_valid", 72'(dc_req_valid), 72'd1);
    chk("sh_dc_we", 72'(dc_we), 72'hC);
    chk("sh_dc_din", 72'(dc_din), 72'hBEEF_BEEF);
    repeat (4) next_cycle();
    chk("sh_stall_cycles", 72'(stall_cycles - s0), 72'd2);
    chk("sh_req_count", 72'(req_log.size() - n0), 72'd1);
    if (req_log.size() > n0) chk("sh_req", 72'(req_log[n0]), {4'd0, 32'h2000, 4'hC, 32'hBEEF_BEEF});
    ready_lat = 0;

    // LW then SW back to back
    resp_lat = 1;
    resp_data = 32'hCAFE_F00D;
    t0 = cyc_n;
    n0 = req_log.size();
    issue(32'h4000, 32'd0, 3'b010, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
    issue(32'h4004, 32'h1122_3344, 3'b010, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    idle_ex();
    wait_drain();
    repeat (3) next_cycle();
    chk("b2b_req_count", 72'(req_log.size() - n0), 72'd2);
    if (req_log.size() >= n0 + 2) begin
      chk("b2b_req0_cycle", 72'(req_cyc[n0]), 72'(t0 + 1));
      chk("b2b_req1_cycle", 72'(req_cyc[n0 + 1]), 72'(t0 + 3));
      chk("b2b_sw_req", 72'(req_log[n0 + 1]), {4'd0, 32'h4004, 4'hF, 32'h1122_3344});
    end
    chk("b2b_bubble", 72'(wb_hist[8'(t0 + 2)]), 72'd0);
    chk("b2b_load_wb_cycle", 72'(last_wb_cyc), 72'(t0 + 3));

    // Reset while waiting in RESP, followed by a stray response
    resp_lat = 10;
    issue(32'h5000, 32'd0, 3'b010, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    idle_ex();
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("mid_stall_before", 72'(stall), 72'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_stall", 72'(stall), 72'd0);
    chk("mid_rst_req_valid", 72'(dc_req_valid), 72'd0);
    chk("mid_rst_prev", {34'd0, prev_reg_we, prev_mem_rr, prev_rd, previous}, 72'd0);
    chk("mid_rst_wb", {34'd0, wb_reg_we, wb_mem_rr, wb_rd, writeback}, 72'd0);
    chk("mid_rst_dc_we", 72'(dc_we), 72'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();
    stray = 1'b1;
    @(negedge clk);
    chk("stray_stall", 72'(stall), 72'd0);
    chk("stray_req_valid", 72'(dc_req_valid), 72'd0);
    next_cycle();
    stray = 1'b0;
    repeat (3) next_cycle();
    chk("stray_no_wb", 72'(wb_reg_we), 72'd0);

    // Misaligned LW
    resp_lat = 1;
    resp_data = 32'h5566_7788;
    s0 = stall_cycles;
    n0 = req_log.size();
`ifdef MEM_ALIGN_CHECK_EN
    issue(32'h3001, 32'd0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    idle_ex();
    @(negedge clk);
    chk("mis_req_valid", 72'(dc_req_valid), 72'd0);
    next_cycle();
    wait_drain();
    repeat (3) next_cycle();
    chk("mis_flag", 72'(misalign), 72'd1);
    chk("mis_req_count", 72'(req_log.size() - n0), 72'd0);
    chk("mis_stall_cycles", 72'(stall_cycles - s0), 72'd0);
`else
    issue(32'h3001, 32'd0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0055_6677);
    idle_ex();
    @(negedge clk);
    chk("mis_req_valid", 72'(dc_req_valid), 72'd1);
    chk("mis_dc_addr", 72'(dc_addr), 72'h3000);
    next_cycle();
    wait_drain();
    repeat (3) next_cycle();
    chk("mis_flag", 72'(misalign), 72'd0);
    chk("mis_req_count", 72'(req_log.size() - n0), 72'd1);
    chk("mis_stall_cycles", 72'(stall_cycles - s0), 72'd1);
`endif

    chk("sb_empty", 72'(sb_q.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
